// File: rtl/fetch_pc_unit.sv
// Program counter and fetch-redirect unit for the IF stage: prioritised redirects,
// one-deep redirect buffer across stalls, target alignment and a redirect counter.
module fetch_pc_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int INST_BYTES = 4,
  parameter int NUM_REDIR = 4,
  parameter int CNT_WIDTH = 16,
  localparam int SRC_WIDTH = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [NUM_REDIR-1:0]            redir_valid,
  input  logic [NUM_REDIR*ADDR_WIDTH-1:0] redir_addr,
  output logic [ADDR_WIDTH-1:0]           inst_addr,
  output logic [ADDR_WIDTH-1:0]           inst_addr_next,
  output logic                            inst_ren,
  output logic                            flush_id,
  output logic                            pending,
  output logic [SRC_WIDTH-1:0]            pending_src,
  output logic                            misalign_err,
  output logic [CNT_WIDTH-1:0]            redir_count
);

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INST_BYTES - 1);

  typedef enum logic {IDLE, HELD} state_t;

  state_t                 state, next_state;
  logic                   live_valid;
  logic [SRC_WIDTH-1:0]   live_idx;
  logic [ADDR_WIDTH-1:0]  live_addr;
  logic [ADDR_WIDTH-1:0]  held_addr;
  logic                   live_wins;
  logic                   commit;
  logic                   capture;
  logic [ADDR_WIDTH-1:0]  raw_target;

  // Lowest-numbered valid source wins; higher indices are ignored this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    live_valid = 1'b0;
    live_idx   = '0;
    live_addr  = '0;
    for (int i = 0; i < NUM_REDIR; i++) begin
      if (redir_valid[i] && !live_valid) begin
        live_valid = 1'b1;
        live_idx   = SRC_WIDTH'(i);
        live_addr  = redir_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // A live request beats the held one when it is of equal or higher priority.
  assign live_wins  = live_valid && ((state == IDLE) || (live_idx <= pending_src));
  assign commit     = en && (live_valid || (state == HELD));
  assign capture    = !en && live_wins;
  assign raw_target = live_wins ? live_addr : held_addr;

  assign inst_addr_next = inst_addr + STEP;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of block ordering.
      state <= next_state;
    end
  end

  // Next-state logic: any enabled cycle consumes or discards the held request.
  always_comb begin
    next_state = state;
    if (en) begin
      next_state = IDLE;
    end else if (live_wins) begin
      next_state = HELD;
    end
  end

  // Output logic.
  always_comb begin
    pending  = (state == HELD);
    flush_id = commit;
  end

  // PC, buffered target and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_addr    <= RESET_VECTOR;
      inst_ren     <= 1'b0;
      held_addr    <= '0;
      pending_src  <= '0;
      misalign_err <= 1'b0;
      redir_count  <= '0;
    end else begin
      inst_ren     <= 1'b1;
      misalign_err <= commit && ((raw_target & ALIGN_MASK) != '0);
      if (en) begin
        inst_addr <= commit ? (raw_target & ~ALIGN_MASK) : inst_addr_next;
      end
      if (capture) begin
        held_addr   <= live_addr;
        pending_src <= live_idx;
      end
      if (commit && (redir_count != '1)) begin
        redir_count <= redir_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_fetch_pc_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [3:0]   redir_valid = '0;
  logic [127:0] redir_addr = '0;

  logic [31:0] b_addr, b_next, s_addr, s_next;
  logic        b_ren, b_flush, b_pend, b_mis, s_ren, s_flush, s_pend, s_mis;
  logic [1:0]  b_src, s_src;
  logic [15:0] b_cnt;
  logic [2:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .INST_BYTES(4),
                  .NUM_REDIR(4), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .redir_valid(redir_valid), .redir_addr(redir_addr),
    .inst_addr(b_addr), .inst_addr_next(b_next), .inst_ren(b_ren), .flush_id(b_flush),
    .pending(b_pend), .pending_src(b_src), .misalign_err(b_mis), .redir_count(b_cnt));

  // Byte-granular PC with a tiny counter, to exercise saturation and the no-mask case.
  fetch_pc_unit #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .INST_BYTES(1),
                  .NUM_REDIR(4), .CNT_WIDTH(3)) u_small (
    .clk(clk), .rst(rst), .en(en), .redir_valid(redir_valid), .redir_addr(redir_addr),
    .inst_addr(s_addr), .inst_addr_next(s_next), .inst_ren(s_ren), .flush_id(s_flush),
    .pending(s_pend), .pending_src(s_src), .misalign_err(s_mis), .redir_count(s_cnt));

  typedef struct {
    logic [31:0] pc;
    bit          ren;
    bit          held;
    int          src;
    logic [31:0] haddr;
    bit          mis;
    int          cnt;
  } model_t;

  model_t mb, ms;

  function automatic model_t model_reset();
    model_t m;
    m.pc = 32'h0; m.ren = 0; m.held = 0; m.src = 0; m.haddr = 32'h0; m.mis = 0; m.cnt = 0;
    return m;
  endfunction

  // One clock edge of the architectural behaviour.
  function automatic model_t model_step(model_t m, logic e, logic [3:0] v, logic [127:0] a,
                                        int ib, int cmax);
    model_t      n = m;
    int          live = -1;
    logic [31:0] take;
    logic [31:0] low = 32'(ib - 1);
    bit          redirect = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) live = i;
    n.ren = 1;
    n.mis = 0;
    if (e) begin
      if (live >= 0 && m.held) begin
        take = (live <= m.src) ? a[live*32 +: 32] : m.haddr;
        redirect = 1;
      end else if (live >= 0) begin
        take = a[live*32 +: 32];
        redirect = 1;
      end else if (m.held) begin
        take = m.haddr;
        redirect = 1;
      end else begin
        take = m.pc + 32'(ib);
      end
      n.held = 0;
      if (redirect) begin
        n.pc  = take & ~low;
        n.mis = (take & low) != 0;
        n.cnt = (m.cnt < cmax) ? m.cnt + 1 : cmax;
      end else begin
        n.pc = take;
      end
    end else if (live >= 0 && (!m.held || live <= m.src)) begin
      n.held  = 1;
      n.src   = live;
      n.haddr = a[live*32 +: 32];
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb <= model_reset();
      ms <= model_reset();
    end else begin
      mb <= model_step(mb, en, redir_valid, redir_addr, 4, 65535);
      ms <= model_step(ms, en, redir_valid, redir_addr, 1, 7);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic exp_flush_b, exp_flush_s;
    exp_flush_b = en && ((|redir_valid) || mb.held);
    exp_flush_s = en && ((|redir_valid) || ms.held);
    check("b.inst_addr", 64'(b_addr), 64'(mb.pc));
    check("b.inst_addr_next", 64'(b_next), 64'(mb.pc + 32'd4));
    check("b.inst_ren", 64'(b_ren), 64'(mb.ren));
    check("b.flush_id", 64'(b_flush), 64'(exp_flush_b));
    check("b.pending", 64'(b_pend), 64'(mb.held));
    check("b.pending_src", 64'(b_src), 64'(mb.src));
    check("b.misalign_err", 64'(b_mis), 64'(mb.mis));
    check("b.redir_count", 64'(b_cnt), 64'(mb.cnt));
    check("s.inst_addr", 64'(s_addr), 64'(ms.pc));
    check("s.inst_addr_next", 64'(s_next), 64'(ms.pc + 32'd1));
    check("s.flush_id", 64'(s_flush), 64'(exp_flush_s));
    check("s.pending", 64'(s_pend), 64'(ms.held));
    check("s.misalign_err", 64'(s_mis), 64'(ms.mis));
    check("s.redir_count", 64'(s_cnt), 64'(ms.cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [31:0] a);
    redir_addr[i*32 +: 32] = a;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset release and sequential fetch.
    tick(); tick();
    @(negedge clk);
    check("rst.inst_addr", 64'(b_addr), 64'h0);
    check("rst.inst_ren", 64'(b_ren), 64'h0);
    tick(); rst = 1'b0; en = 1'b1;
    @(negedge clk);
    check("t1.ren_before_edge", 64'(b_ren), 64'h0);
    check("t1.flush", 64'(b_flush), 64'h0);
    tick(); @(negedge clk);
    check("t1.pc4", 64'(b_addr), 64'h4);
    check("t1.ren", 64'(b_ren), 64'h1);
    tick(); @(negedge clk); check("t1.pc8", 64'(b_addr), 64'h8);
    tick(); @(negedge clk); check("t1.pcC", 64'(b_addr), 64'hC);

    // Live redirect while running.
    tick(); redir_valid = 4'b0100; set_addr(2, 32'h200);
    @(negedge clk);
    check("t2.pc10", 64'(b_addr), 64'h10);
    check("t2.flush", 64'(b_flush), 64'h1);
    tick(); redir_valid = '0;
    @(negedge clk);
    check("t2.pc", 64'(b_addr), 64'h200);
    check("t2.flush_off", 64'(b_flush), 64'h0);
    check("t2.count", 64'(b_cnt), 64'h1);

    // Stalled capture, overwritten by a higher-priority source.
    tick(); en = 1'b0; redir_valid = 4'b1000; set_addr(3, 32'h300);
    @(negedge clk); check("t3.stall_flush", 64'(b_flush), 64'h0);
    tick(); redir_valid = 4'b0001; set_addr(0, 32'h8000_0180);
    @(negedge clk);
    check("t3.pending", 64'(b_pend), 64'h1);
    check("t3.src3", 64'(b_src), 64'h3);
    check("t3.pc_hold", 64'(b_addr), 64'h204);
    tick(); redir_valid = '0;
    @(negedge clk); check("t3.src0", 64'(b_src), 64'h0);
    tick(); en = 1'b1;
    @(negedge clk); check("t3.flush_held", 64'(b_flush), 64'h1);
    tick(); @(negedge clk);
    check("t3.pc", 64'(b_addr), 64'h8000_0180);
    check("t3.pending_clr", 64'(b_pend), 64'h0);
    check("t3.count", 64'(b_cnt), 64'h2);

    // Held src 1 beats live src 2.
    tick(); en = 1'b0; redir_valid = 4'b0010; set_addr(1, 32'h400);
    @(negedge clk);
    tick(); en = 1'b1; redir_valid = 4'b0100; set_addr(2, 32'h500);
    @(negedge clk);
    check("t4.src1", 64'(b_src), 64'h1);
    tick(); redir_valid = '0;
    @(negedge clk);
    check("t4.pc", 64'(b_addr), 64'h400);
    check("t4.count", 64'(b_cnt), 64'h3);
    tick(); @(negedge clk);
    check("t4.discarded", 64'(b_addr), 64'h404);

    // Misaligned target.
    tick(); redir_valid = 4'b0010; set_addr(1, 32'h1003);
    @(negedge clk);
    tick(); redir_valid = '0;
    @(negedge clk);
    check("t5.pc", 64'(b_addr), 64'h1000);
    check("t5.misalign", 64'(b_mis), 64'h1);
    check("t5.small_no_mis", 64'(s_mis), 64'h0);
    check("t5.small_pc", 64'(s_addr), 64'h1003);
    tick(); @(negedge clk);
    check("t5.misalign_off", 64'(b_mis), 64'h0);

    // Ten back-to-back redirects: small counter saturates.
    tick(); redir_valid = 4'b0001; set_addr(0, 32'h2000);
    repeat (10) tick();
    redir_valid = '0;
    @(negedge clk);
    check("sat.big_count", 64'(b_cnt), 64'd14);
    check("sat.small_count", 64'(s_cnt), 64'h7);
    check("sat.pc", 64'(b_addr), 64'h2000);

    // Reset in the middle of a stall with a held redirect.
    tick(); en = 1'b0; redir_valid = 4'b0100; set_addr(2, 32'h700);
    tick(); redir_valid = '0;
    @(negedge clk);
    check("t6.pending", 64'(b_pend), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("t6.async_pc", 64'(b_addr), 64'h0);
    check("t6.async_pending", 64'(b_pend), 64'h0);
    check("t6.async_count", 64'(b_cnt), 64'h0);
    tick(); tick(); rst = 1'b0; en = 1'b1;
    @(negedge clk); check("t6.pc0", 64'(b_addr), 64'h0);
    tick(); @(negedge clk);
    check("t6.pc4", 64'(b_addr), 64'h4);
    check("t6.no_redirect", 64'(b_cnt), 64'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        redir_valid[i] = ($urandom_range(0, 5) == 0);
        set_addr(i, $urandom);
      end
    end
    tick();
    rst = 1'b0;
    redir_valid = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
